// File: rtl/main_tx_source.sv
`default_nettype none
// ============================================================================
// Module      : main_tx_source
// Description : Buffers upstream words in a small FIFO and writes them into
//               the Main FIFO when it is not paused or full. Keeps
//               per-destination sent counters and flags a Main FIFO
//               threshold violation (full without pause) as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module main_tx_source #(
    parameter int BW    = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             in_valid,
    input  logic [BW-1:0]    in_data,
    output logic             in_ready,
    input  logic             Main_full,
    input  logic             Main_pause,
    output logic             Main_wr,
    output logic [BW-1:0]    Main_data,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out,
    output logic [CNT_W-1:0] cnt_d0,
    output logic [CNT_W-1:0] cnt_d1
);

    // DEPTH is a power of two of at least 2, so the pointers wrap naturally.
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [BW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_main_wr;
    logic [BW-1:0]    r_main_data;
    logic [CNT_W-1:0] r_cnt_d0;
    logic [CNT_W-1:0] r_cnt_d1;
    logic             r_idle;
    logic             r_active;
    logic             r_error;

    logic             w_run;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;
    logic [BW-1:0]    w_head;

    // Flushing covers both the cycle init is raised and every INIT cycle,
    // so INIT is always entered with an empty buffer and cleared counters.
    assign w_run    = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    assign w_flush  = init || (r_state == S_INIT);
    assign in_ready = w_run && (r_count < C_DEPTH);
    assign w_push   = in_valid && in_ready && !w_flush;
    assign w_pop    = w_run && (r_count != '0) && !Main_pause && !Main_full && !init;
    assign w_head   = r_mem[r_rd_ptr];

    assign Main_wr    = r_main_wr;
    assign Main_data  = r_main_data;
    assign cnt_d0     = r_cnt_d0;
    assign cnt_d1     = r_cnt_d1;
    assign idle_out   = r_idle;
    assign active_out = r_active;
    assign error_out  = r_error;

    // Next-state selection; init outranks the threshold-violation check.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET: if (init) w_state_nxt = S_INIT;
            S_INIT:  if (!init) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (init)                          w_state_nxt = S_INIT;
                else if (Main_full && !Main_pause) w_state_nxt = S_ERROR;
                else if (r_count != '0)            w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (init)                               w_state_nxt = S_INIT;
                else if (Main_full && !Main_pause)      w_state_nxt = S_ERROR;
                else if (r_count == '0 && !r_main_wr)   w_state_nxt = S_IDLE;
            end
            S_ERROR: if (init) w_state_nxt = S_INIT;
            default: w_state_nxt = S_RESET;
        endcase
    end

    // State register with registered one-hot status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_RESET;
            r_idle   <= 1'b0;
            r_active <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idle   <= (w_state_nxt == S_IDLE);
            r_active <= (w_state_nxt == S_ACTIVE);
            r_error  <= (w_state_nxt == S_ERROR);
        end
    end

    // Buffer storage; contents need no reset because the count qualifies them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered Main FIFO write port and per-destination counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_wr   <= 1'b0;
            r_main_data <= '0;
            r_cnt_d0    <= '0;
            r_cnt_d1    <= '0;
        end else if (w_flush) begin
            r_main_wr <= 1'b0;
            r_cnt_d0  <= '0;
            r_cnt_d1  <= '0;
        end else begin
            r_main_wr <= w_pop;
            if (w_pop) begin
                r_main_data <= w_head;
                if (w_head[BW-1]) r_cnt_d1 <= r_cnt_d1 + 1'b1;
                else              r_cnt_d0 <= r_cnt_d0 + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_tx_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_tx_source
// Description : Self-checking bench for main_tx_source with a queue-based
//               reference model and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_tx_source;

    localparam int BW    = 6;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    typedef enum int {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mstate_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic             in_valid;
    logic [BW-1:0]    in_data;
    logic             in_ready;
    logic             Main_full;
    logic             Main_pause;
    logic             Main_wr;
    logic [BW-1:0]    Main_data;
    logic             idle_out;
    logic             active_out;
    logic             error_out;
    logic [CNT_W-1:0] cnt_d0;
    logic [CNT_W-1:0] cnt_d1;

    int checks   = 0;
    int failures = 0;

    mstate_t          ms;
    logic [BW-1:0]    q [$];
    logic             m_wr;
    logic [BW-1:0]    m_data;
    logic [CNT_W-1:0] m_c0;
    logic [CNT_W-1:0] m_c1;

    main_tx_source #(.BW(BW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .Main_full  (Main_full),
        .Main_pause (Main_pause),
        .Main_wr    (Main_wr),
        .Main_data  (Main_data),
        .idle_out   (idle_out),
        .active_out (active_out),
        .error_out  (error_out),
        .cnt_d0     (cnt_d0),
        .cnt_d1     (cnt_d1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return (ms == M_IDLE || ms == M_ACTIVE) && (q.size() < DEPTH);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
        chk({tag, ".Main_wr"}, 32'(Main_wr), 32'(m_wr));
        chk({tag, ".Main_data"}, 32'(Main_data), 32'(m_data));
        chk({tag, ".cnt_d0"}, 32'(cnt_d0), 32'(m_c0));
        chk({tag, ".cnt_d1"}, 32'(cnt_d1), 32'(m_c1));
        chk({tag, ".idle"}, 32'(idle_out), 32'(ms == M_IDLE));
        chk({tag, ".active"}, 32'(active_out), 32'(ms == M_ACTIVE));
        chk({tag, ".error"}, 32'(error_out), 32'(ms == M_ERROR));
    endtask

    task automatic model_reset();
        ms = M_RESET;
        q.delete();
        m_wr   = 1'b0;
        m_data = '0;
        m_c0   = '0;
        m_c1   = '0;
    endtask

    // Advance the model by one rising edge using the inputs presently applied.
    task automatic model_step();
        bit run, push, pop, flush;
        mstate_t nms;
        logic [BW-1:0] w;
        run   = (ms == M_IDLE || ms == M_ACTIVE);
        push  = in_valid && model_ready();
        pop   = run && q.size() > 0 && !Main_pause && !Main_full && !init;
        flush = init || ms == M_INIT;
        nms   = ms;
        case (ms)
            M_RESET: nms = init ? M_INIT : M_RESET;
            M_INIT:  nms = init ? M_INIT : M_IDLE;
            M_ERROR: nms = init ? M_INIT : M_ERROR;
            default: begin
                if (init) nms = M_INIT;
                else if (Main_full && !Main_pause) nms = M_ERROR;
                else if (ms == M_IDLE && q.size() != 0) nms = M_ACTIVE;
                else if (ms == M_ACTIVE && q.size() == 0 && !m_wr) nms = M_IDLE;
            end
        endcase
        if (flush) begin
            q.delete();
            m_wr = 1'b0;
            m_c0 = '0;
            m_c1 = '0;
        end else begin
            m_wr = pop;
            if (pop) begin
                w = q.pop_front();
                m_data = w;
                if (w[BW-1]) m_c1 = m_c1 + 1'b1;
                else         m_c0 = m_c0 + 1'b1;
            end
            if (push) q.push_back(in_data);
        end
        ms = nms;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_init();
        init = 1'b1;
        tick("init_hi");
        init = 1'b0;
        tick("init_lo");
    endtask

    initial begin
        logic [BW-1:0] words [4];
        int n;

        reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0;
        Main_full = 1'b0; Main_pause = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;
        tick("reset_hold");
        tick("reset_hold");

        // Single init pulse then a single word to D0.
        do_init();
        chk("idle_after_init", 32'(idle_out), 32'd1);
        in_valid = 1'b1; in_data = 6'h05;
        tick("push05");
        in_valid = 1'b0;
        tick("pop05");
        chk("d035_wr", 32'(Main_wr), 32'd1);
        chk("d035_data", 32'(Main_data), 32'h05);
        repeat (3) tick("drain05");
        chk("d035_cnt_d0", 32'(cnt_d0), 32'd1);
        chk("d035_idle", 32'(idle_out), 32'd1);

        // Fill the buffer under pause, then release and drain in order.
        Main_pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            words[i] = BW'($urandom);
            in_valid = 1'b1; in_data = words[i];
            tick("pause_push");
        end
        in_valid = 1'b0;
        chk("d036_ready_full", 32'(in_ready), 32'd0);
        chk("d036_no_wr", 32'(Main_wr), 32'd0);
        Main_pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("pause_release");
            chk("d036_wr", 32'(Main_wr), 32'd1);
            chk("d036_data", 32'(Main_data), 32'(words[i]));
        end
        repeat (3) tick("drain36");

        // Threshold violation in ACTIVE, then recovery via init.
        Main_pause = 1'b1; in_valid = 1'b1; in_data = BW'($urandom);
        tick("err_push");
        in_valid = 1'b0;
        tick("err_active");
        chk("d037_active", 32'(active_out), 32'd1);
        Main_pause = 1'b0; Main_full = 1'b1;
        tick("err_enter");
        chk("d037_error", 32'(error_out), 32'd1);
        chk("d037_ready", 32'(in_ready), 32'd0);
        Main_full = 1'b0;
        tick("err_hold");
        init = 1'b1;
        tick("err_init");
        chk("d037_cnt_d0", 32'(cnt_d0), 32'd0);
        chk("d037_cnt_d1", 32'(cnt_d1), 32'd0);
        init = 1'b0;
        repeat (3) tick("err_recover");
        chk("d037_no_stale", 32'(Main_wr), 32'd0);

        // 256 words to D1: counter wraps to zero.
        n = 0;
        while (n < 256) begin
            in_valid = 1'b1; in_data = BW'($urandom) | 6'h20;
            if (model_ready()) n++;
            tick("wrap_push");
        end
        in_valid = 1'b0;
        repeat (6) tick("wrap_drain");
        chk("d038_cnt_d1", 32'(cnt_d1), 32'd0);
        chk("d038_cnt_d0", 32'(cnt_d0), 32'd0);

        // Reset with buffered words: nothing stale afterwards.
        Main_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = BW'($urandom);
            tick("rst_push");
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        reset = 1'b0;
        Main_pause = 1'b0;
        tick("rst_release");
        do_init();
        for (int i = 0; i < 5; i++) begin
            tick("rst_no_stale");
            chk("d039_no_wr", 32'(Main_wr), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = BW'($urandom);
            Main_pause = ($urandom_range(0, 3) == 0);
            Main_full  = Main_pause ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
            init       = (ms == M_ERROR) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            tick("random");
        end
        in_valid = 1'b0; Main_pause = 1'b0; Main_full = 1'b0; init = 1'b0;
        repeat (4) tick("random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_tx_source.md
MAIN_TX_SOURCE -- requirements
Module: main_tx_source

Interface
REQ-001 SHALL have parameter BW, default 6: word width, matching Main FIFO data width.
REQ-002 SHALL have parameter DEPTH, default 4: internal holding-buffer entries (power of two).
REQ-003 SHALL have parameter CNT_W, default 8: width of per-destination sent-word counters.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port init  input  1  level request to (re)initialise: flush buffer, clear counters and error.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_data  input  BW  upstream word; bit BW-1 = destination (0=D0, 1=D1), bit BW-2 = VC id.
REQ-009 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-010 SHALL have port Main_full  input  1  Main FIFO full flag.
REQ-011 SHALL have port Main_pause  input  1  Main FIFO almost-full (high-threshold) flag.
REQ-012 SHALL have port Main_wr  output  1  write strobe into Main FIFO.
REQ-013 SHALL have port Main_data  output  BW  word written into Main FIFO, valid while Main_wr=1.
REQ-014 SHALL have ports idle_out, active_out, error_out  output  1 each  one-hot state indication.
REQ-015 SHALL have ports cnt_d0, cnt_d1  output  CNT_W each  words written to Main per destination.

Function
REQ-016 SHALL implement states RESET, INIT, IDLE, ACTIVE, ERROR.
REQ-017 SHALL transition RESET->INIT when init=1; otherwise remain in RESET.
REQ-018 SHALL transition INIT->IDLE when init=0; remain in INIT while init=1.
REQ-019 SHALL transition IDLE->ACTIVE when buffer count becomes nonzero.
REQ-020 SHALL transition ACTIVE->IDLE when buffer count is zero and Main_wr is low.
REQ-021 SHALL transition IDLE or ACTIVE -> INIT when init=1 (highest priority over ERROR detection).
REQ-022 SHALL transition IDLE or ACTIVE -> ERROR when Main_full=1 while Main_pause=0 (threshold violation); ERROR exits only via init=1 -> INIT.
REQ-023 SHALL, in INIT, empty the buffer, clear cnt_d0/cnt_d1, hold Main_wr=0.
REQ-024 SHALL drive in_ready=1 only in IDLE or ACTIVE with buffer count < DEPTH (combinational); a full buffer deasserts in_ready even if a pop occurs the same cycle.
REQ-025 SHALL push in_data into the buffer on each edge where in_valid=1 and in_ready=1.
REQ-026 SHALL pop the buffer head when state is IDLE/ACTIVE, count>0, Main_pause=0, Main_full=0, init=0.
REQ-027 SHALL register Main_wr and Main_data: a pop at edge E drives Main_wr=1 and Main_data=popped word during the cycle after E; otherwise Main_wr=0 and Main_data holds its last value.
REQ-028 SHALL give latency: word accepted at edge E0 into an empty buffer with pop allowed appears on Main_wr/Main_data after edge E0+1 (2-edge latency); order strictly FIFO.
REQ-029 SHALL support simultaneous push and pop in one cycle, count unchanged.
REQ-030 SHALL increment cnt_d0 (bit BW-1=0) or cnt_d1 (bit BW-1=1) on each edge where a pop occurs; wrap 2^CNT_W-1 -> 0.
REQ-031 SHALL never write while Main_pause or Main_full is high; buffered words wait, not dropped.
REQ-032 SHALL drive idle_out in IDLE, active_out in ACTIVE, error_out in ERROR; all three low in RESET and INIT.

Reset
REQ-033 SHALL on reset=1, asynchronously: state=RESET, buffer empty, Main_wr=0, Main_data=0, cnt_d0=cnt_d1=0, in_ready=0, idle/active/error outputs=0.
REQ-034 SHALL discard buffered words when reset asserts mid-operation; no write strobe after reset asserts.

Verification
REQ-035 SHALL cover: reset, init=1 one cycle, push 0x05 -> Main_wr=1, Main_data=0x05 two edges later; cnt_d0=1, idle_out returns to 1.
REQ-036 SHALL cover: Main_pause=1, push 4 words -> in_ready=0 after 4th, Main_wr stays 0; release pause -> 4 writes in order on 4 consecutive cycles.
REQ-037 SHALL cover: Main_full=1 with Main_pause=0 in ACTIVE -> error_out=1 next cycle, in_ready=0; init=1 -> INIT, counters 0, buffer empty.
REQ-038 SHALL cover: 256 words with bit5=1 -> cnt_d1 wraps to 0, cnt_d0 stays 0.
REQ-039 SHALL cover: reset asserted with 3 buffered words -> Main_wr=0 immediately, after release and init no stale word emitted.
